cl_write_sequencer: RTL and testbench

//  Downstream consumer of the AFU write-data FIFO. Pops processed CLs and issues

---
 rtl/cl_write_sequencer_pkg.sv | 16 +
 rtl/cl_write_sequencer_addr.sv | 46 ++++
 rtl/cl_write_sequencer.sv | 150 +++++++++++++++
 tb/tb_cl_write_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_write_sequencer_pkg.sv
// rtl/cl_write_sequencer_pkg.sv - shared types and constants for the CL write sequencer
//
// Contents:
//   e_wr_seq_state        sequencer FSM states (IDLE, STREAM, STATUS)
//   STATUS_MAGIC_DEFAULT  marker placed in bits [31:0] of every status CL
package interface_debug;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    STATUS = 2'd2
  } e_wr_seq_state;

  localparam logic [31:0] STATUS_MAGIC_DEFAULT = 32'hD0E5_0001;

endpackage

// File: rtl/cl_write_sequencer_addr.sv
// rtl/cl_write_sequencer_addr.sv - run base latch, CL offset counter and write address add
//
// Module cl_addr_counter
//   clk        in   1       clock
//   reset      in   1       synchronous, active-high reset
//   load       in   1       start of a run: capture load_base, clear offset
//   load_base  in   ADDR_W  first CL address of the run
//   advance    in   1       a data CL was popped: step the offset
//   addr       out  ADDR_W  address for the CL popped this cycle (base + offset)
//
// The sum is combinational so the top-level output register captures it in the
// same cycle as the pop; that keeps the pop-to-beat latency at one cycle.
module cl_addr_counter #(
  parameter int ADDR_W = 42,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  offset;

  always_ff @(posedge clk) begin
    if (reset) begin
      base   <= '0;
      offset <= '0;
    end else if (load) begin
      base   <= load_base;
      offset <= '0;
    end else if (advance) begin
      // Offset wraps modulo 2^CNT_W by natural overflow.
      offset <= offset + CNT_ONE;
    end
  end

  // Address wraps modulo 2^ADDR_W by natural overflow.
  assign addr = base + ADDR_W'(offset);

endmodule

// File: rtl/cl_write_sequencer.sv
// rtl/cl_write_sequencer.sv - pops processed CLs and issues sequential CL writes plus a status CL
//
// Module cl_write_sequencer
//   clk         in   1       clock
//   reset       in   1       synchronous, active-high reset
//   stall       in   1       downstream almost-full; no beat issued while high
//   run         in   1       AFU run state
//   start_addr  in   ADDR_W  first data CL address, captured when a run starts
//   stts_addr   in   ADDR_W  status CL address, captured when the status beat issues
//   stts_req    in   1       pulse: request a status CL write
//   stts_nonce  in   32      nonce for the status CL, captured with stts_req
//   fifo_empty  in   1       show-ahead write-data FIFO empty
//   fifo_data   in   DATA_W  FIFO head word
//   fifo_rd_en  out  1       pop FIFO head (combinational)
//   wr_valid    out  1       write beat valid (registered)
//   wr_addr     out  ADDR_W  write CL address (registered)
//   wr_data     out  DATA_W  write CL data (registered)
//   num_cls_wr  out  CNT_W   data CLs issued in the current/last run
//   stts_done   out  1       pulse, cycle after the status beat
module cl_write_sequencer
  import interface_debug::*;
#(
  parameter int          ADDR_W       = 42,
  parameter int          DATA_W       = 512,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] STATUS_MAGIC = STATUS_MAGIC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              run,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] stts_addr,
  input  logic              stts_req,
  input  logic [31:0]       stts_nonce,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  num_cls_wr,
  output logic              stts_done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  e_wr_seq_state     state;
  logic              pending;
  logic [31:0]       nonce;
  logic              stts_beat;

  logic              pop;
  logic              stts_fire;
  logic              start_run;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] stts_word;

  // Pops only while streaming with run still high; gated by reset so nothing
  // leaves the FIFO in the reset cycle even if the state register was mid-run.
  assign pop        = (state == STREAM) && run && !stall && !fifo_empty && !reset;
  assign fifo_rd_en = pop;
  assign stts_fire  = (state == STATUS) && !stall;
  assign start_run  = (state == IDLE) && run;

  cl_addr_counter #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (start_run),
    .load_base (start_addr),
    .advance   (pop),
    .addr      (data_addr)
  );

  // Status CL layout: magic in [31:0], nonce in [63:32], CL count above, rest zero.
  always_comb begin
    stts_word                = '0;
    stts_word[31:0]          = STATUS_MAGIC;
    stts_word[63:32]         = nonce;
    stts_word[64 +: CNT_W]   = num_cls_wr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      nonce      <= '0;
      stts_beat  <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      num_cls_wr <= '0;
      stts_done  <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      stts_beat <= 1'b0;
      stts_done <= stts_beat;

      // Status is only entered from IDLE with run low, so a request made during
      // a run waits until every data CL of that run has been issued.
      case (state)
        IDLE: begin
          if (run) begin
            state      <= STREAM;
            num_cls_wr <= '0;
          end else if (pending) begin
            state <= STATUS;
          end
        end
        STREAM: begin
          if (!run) begin
            state <= IDLE;
          end
        end
        STATUS: begin
          if (!stall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (pop) begin
        wr_valid   <= 1'b1;
        wr_addr    <= data_addr;
        wr_data    <= fifo_data;
        num_cls_wr <= num_cls_wr + CNT_ONE;
      end

      if (stts_fire) begin
        wr_valid  <= 1'b1;
        wr_addr   <= stts_addr;
        wr_data   <= stts_word;
        stts_beat <= 1'b1;
        pending   <= 1'b0;
      end

      // A fresh request wins over the clear so it is never lost; a repeat
      // request while pending just refreshes the nonce.
      if (stts_req) begin
        pending <= 1'b1;
        nonce   <= stts_nonce;
      end
    end
  end

endmodule

// File: tb/tb_cl_write_sequencer.sv
// tb/tb_cl_write_sequencer.sv - self-checking bench for cl_write_sequencer
module tb_cl_write_sequencer;

  logic         clk;
  logic         reset;
  logic         stall;
  logic         run;
  logic [41:0]  start_addr;
  logic [41:0]  stts_addr;
  logic         stts_req;
  logic [31:0]  stts_nonce;
  logic         fifo_empty;
  logic [511:0] fifo_data;
  logic         fifo_rd_en;
  logic         wr_valid;
  logic [41:0]  wr_addr;
  logic [511:0] wr_data;
  logic [31:0]  num_cls_wr;
  logic         stts_done;

  cl_write_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .run        (run),
    .start_addr (start_addr),
    .stts_addr  (stts_addr),
    .stts_req   (stts_req),
    .stts_nonce (stts_nonce),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .num_cls_wr (num_cls_wr),
    .stts_done  (stts_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Behavioural FIFO feeding the DUT.
  logic [511:0] fq [$];

  // Observed beat log.
  logic [41:0]  lg_addr [$];
  logic [511:0] lg_data [$];
  int           lg_cyc  [$];
  int           done_cyc [$];

  // Reference model state: what the spec says the outputs must be.
  bit           m_stream = 0;
  bit           m_sts    = 0;
  bit           m_pend   = 0;
  bit           m_sbeat  = 0;
  bit           m_valid  = 0;
  bit           m_done   = 0;
  logic [41:0]  m_base   = '0;
  logic [41:0]  m_addr   = '0;
  logic [31:0]  m_n      = '0;
  logic [31:0]  m_nonce  = '0;
  logic [511:0] m_data   = '0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] status_word(input logic [31:0] n, input logic [31:0] nn);
    status_word = {416'b0, n, nn, 32'hD0E5_0001};
  endfunction

  task automatic fifo_upd();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() == 0) ? '0 : fq[0];
  endtask

  task automatic push(input logic [511:0] d);
    fq.push_back(d);
    fifo_upd();
  endtask

  task automatic clear_log();
    lg_addr.delete();
    lg_data.delete();
    lg_cyc.delete();
    done_cyc.delete();
  endtask

  // One clock: predict from current inputs, cross the edge, compare on negedge.
  task automatic tick();
    logic         exp_rd;
    logic         act_rd;
    logic         do_pop;
    logic         do_sts;
    logic         was_idle;
    logic         was_stream;
    logic [511:0] head;
    exp_rd     = 1'b0;
    do_pop     = 1'b0;
    do_sts     = 1'b0;
    was_idle   = 1'b0;
    was_stream = 1'b0;
    #1;
    head = (fq.size() > 0) ? fq[0] : '0;
    if (reset) begin
      m_stream = 0; m_sts = 0; m_pend = 0; m_sbeat = 0;
      m_valid = 0; m_done = 0; m_n = '0; m_addr = '0; m_data = '0; m_nonce = '0;
    end else begin
      was_idle   = !m_stream && !m_sts;
      was_stream = m_stream;
      do_pop     = m_stream && run && !stall && (fq.size() > 0);
      do_sts     = m_sts && !stall;
      exp_rd     = do_pop;
      m_done     = m_sbeat;
      m_sbeat    = 0;
      m_valid    = 0;
      if (do_pop) begin
        m_valid = 1;
        m_addr  = m_base + 42'(m_n);
        m_data  = head;
        m_n     = m_n + 32'd1;
      end
      if (do_sts) begin
        m_valid = 1;
        m_addr  = stts_addr;
        m_data  = status_word(m_n, m_nonce);
        m_sbeat = 1;
        m_pend  = 0;
        m_sts   = 0;
      end
      if (was_idle && run) begin
        m_stream = 1;
        m_base   = start_addr;
        m_n      = '0;
      end else if (was_idle && m_pend) begin
        m_sts = 1;
      end
      if (was_stream && !run) m_stream = 0;
      if (stts_req) begin
        m_pend  = 1;
        m_nonce = stts_nonce;
      end
    end
    act_rd = fifo_rd_en;
    chk("fifo_rd_en", 512'(act_rd), 512'(exp_rd));
    @(negedge clk);
    cyc++;
    if (act_rd && fq.size() > 0) void'(fq.pop_front());
    fifo_upd();
    chk("wr_valid", 512'(wr_valid), 512'(m_valid));
    chk("wr_addr", 512'(wr_addr), 512'(m_addr));
    chk("wr_data", wr_data, m_data);
    chk("num_cls_wr", 512'(num_cls_wr), 512'(m_n));
    chk("stts_done", 512'(stts_done), 512'(m_done));
    if (wr_valid) begin
      lg_addr.push_back(wr_addr);
      lg_data.push_back(wr_data);
      lg_cyc.push_back(cyc);
    end
    if (stts_done) done_cyc.push_back(cyc);
  endtask

  initial begin
    logic [63:0]  r64;
    logic [511:0] w;
    logic [41:0]  sa;
    reset = 1; stall = 0; run = 0; start_addr = '0; stts_addr = '0;
    stts_req = 0; stts_nonce = '0;
    fifo_upd();
    @(negedge clk);
    tick();
    tick();
    chk("reset_wr_valid", 512'(wr_valid), 512'(0));
    chk("reset_num_cls_wr", 512'(num_cls_wr), 512'(0));
    reset = 0;
    tick();

    // 1: basic run of 4 CLs
    clear_log();
    start_addr = 42'h100;
    for (int i = 0; i < 4; i++) push(512'(i));
    run = 1;
    repeat (7) tick();
    chk("s1_beats", 512'(lg_addr.size()), 512'(4));
    for (int i = 0; i < 4 && i < lg_addr.size(); i++) begin
      chk("s1_addr", 512'(lg_addr[i]), 512'(42'h100 + 42'(i)));
      chk("s1_data", lg_data[i], 512'(i));
    end
    chk("s1_count", 512'(num_cls_wr), 512'(4));

    // 2: stall with 3 CLs queued
    clear_log();
    stall = 1;
    for (int i = 0; i < 3; i++) push(512'(100 + i));
    repeat (10) tick();
    chk("s2_no_beat_stalled", 512'(lg_addr.size()), 512'(0));
    stall = 0;
    repeat (5) tick();
    chk("s2_beats", 512'(lg_addr.size()), 512'(3));
    for (int i = 0; i < 3 && i < lg_addr.size(); i++) begin
      chk("s2_addr", 512'(lg_addr[i]), 512'(42'h104 + 42'(i)));
      chk("s2_data", lg_data[i], 512'(100 + i));
      chk("s2_no_gap", 512'(lg_cyc[i]), 512'(lg_cyc[0] + i));
    end
    chk("s2_count", 512'(num_cls_wr), 512'(7));

    // 3: status request during a run
    run = 0;
    repeat (2) tick();
    clear_log();
    start_addr = 42'h200;
    stts_addr  = 42'h3AB_CDEF_0040;
    run = 1; stall = 1;
    push(512'h0A0);
    push(512'h0A1);
    tick();
    stts_req = 1; stts_nonce = 32'h0000_ABCD;
    tick();
    stts_req = 0; stall = 0;
    repeat (4) tick();
    run = 0;
    repeat (8) tick();
    chk("s3_beats", 512'(lg_addr.size()), 512'(3));
    if (lg_addr.size() >= 3) begin
      chk("s3_addr0", 512'(lg_addr[0]), 512'(42'h200));
      chk("s3_addr1", 512'(lg_addr[1]), 512'(42'h201));
      chk("s3_stts_addr", 512'(lg_addr[2]), 512'(42'h3AB_CDEF_0040));
      w = lg_data[2];
      chk("s3_magic", 512'(w[31:0]), 512'(32'hD0E5_0001));
      chk("s3_nonce", 512'(w[63:32]), 512'(32'h0000_ABCD));
      chk("s3_count", 512'(w[95:64]), 512'(2));
      chk("s3_upper_zero", 512'(w[511:96]), 512'(0));
    end
    chk("s3_done_once", 512'(done_cyc.size()), 512'(1));
    if (done_cyc.size() >= 1 && lg_cyc.size() >= 3)
      chk("s3_done_time", 512'(done_cyc[0]), 512'(lg_cyc[2] + 1));

    // 4: address wrap at 2^42
    clear_log();
    start_addr = 42'h3FF_FFFF_FFFE;
    for (int i = 0; i < 4; i++) push(512'($urandom));
    run = 1;
    repeat (7) tick();
    run = 0;
    repeat (2) tick();
    chk("s4_beats", 512'(lg_addr.size()), 512'(4));
    if (lg_addr.size() >= 4) begin
      chk("s4_addr0", 512'(lg_addr[0]), 512'(42'h3FF_FFFF_FFFE));
      chk("s4_addr1", 512'(lg_addr[1]), 512'(42'h3FF_FFFF_FFFF));
      chk("s4_addr2", 512'(lg_addr[2]), 512'(0));
      chk("s4_addr3", 512'(lg_addr[3]), 512'(1));
    end

    // 5: reset mid-stream with a pending status request
    clear_log();
    start_addr = 42'h500;
    for (int i = 0; i < 6; i++) push(512'(8'h50 + i));
    run = 1;
    tick();
    tick();
    stts_req = 1; stts_nonce = 32'h1234;
    tick();
    stts_req = 0;
    reset = 1;
    start_addr = 42'h700;
    tick();
    chk("s5_reset_valid", 512'(wr_valid), 512'(0));
    chk("s5_reset_count", 512'(num_cls_wr), 512'(0));
    reset = 0;
    clear_log();
    repeat (8) tick();
    run = 0;
    repeat (8) tick();
    chk("s5_beats", 512'(lg_addr.size()), 512'(4));
    if (lg_addr.size() >= 1) begin
      chk("s5_restart_addr", 512'(lg_addr[0]), 512'(42'h700));
      chk("s5_restart_data", lg_data[0], 512'(8'h52));
    end
    chk("s5_no_status", 512'(done_cyc.size()), 512'(0));

    // 6: run low with a non-empty FIFO
    clear_log();
    for (int i = 0; i < 3; i++) push(512'($urandom));
    repeat (6) tick();
    chk("s6_no_beats", 512'(lg_addr.size()), 512'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      stall = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 8) run = ~run;
      if (fq.size() < 8 && $urandom_range(0, 99) < 50)
        push({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      stts_req   = ($urandom_range(0, 99) < 6);
      stts_nonce = $urandom;
      r64 = {$urandom, $urandom};
      sa  = r64[41:0];
      if ($urandom_range(0, 3) == 0) sa = 42'h3FF_FFFF_FFF0 | 42'(r64[3:0]);
      start_addr = sa;
      r64 = {$urandom, $urandom};
      stts_addr = r64[41:0];
      reset = ($urandom_range(0, 99) < 2);
      tick();
    end
    reset = 0; run = 0; stall = 0; stts_req = 0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
